// File: rtl/clk_period_monitor.sv
// Period checker for an asynchronous clock-like input: counts clk cycles between
// rising edges of mon_in and flags periods outside EXP_PERIOD +/- TOL, plus stalls.
module clk_period_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EXP_PERIOD  = 36,
  parameter int unsigned TOL         = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             period_err,
  output logic             too_short,
  output logic             too_long,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned LO      = 64'(EXP_PERIOD) - 64'(TOL);
  localparam longint unsigned HI_RAW  = 64'(EXP_PERIOD) + 64'(TOL);
  localparam longint unsigned HI      = (HI_RAW > CNT_MAX) ? CNT_MAX : HI_RAW;
  // A stall can only be seen if the counter can actually reach hi+1.
  localparam bit              TO_EN   = (HI_RAW < CNT_MAX);

  localparam logic [CNT_W-1:0] LO_V = CNT_W'(LO);
  localparam logic [CNT_W-1:0] HI_V = CNT_W'(HI);
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(HI + 64'd1);
  localparam logic [CNT_W-1:0] ALL1 = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic                   edge_q, edge_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   to_fired_q, to_fired_d;
  logic [CNT_W-1:0]       period_out_q, period_out_d;
  logic                   period_valid_q, period_valid_d;
  logic                   period_err_q, period_err_d;
  logic                   too_short_q, too_short_d;
  logic                   too_long_q, too_long_d;
  logic                   err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]       pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;

  // Synchronizer and registered rising-edge detector.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], mon_in};
    s_dly_d = sync_q[SYNC_STAGES-1];
    edge_d  = sync_q[SYNC_STAGES-1] & ~s_dly_q;
  end

  // Measurement FSM, window classification and status counters.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    to_fired_d     = to_fired_q;
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    period_err_d   = 1'b0;
    too_short_d    = 1'b0;
    too_long_d     = 1'b0;
    pass_cnt_d     = pass_cnt_q;
    fail_cnt_d     = fail_cnt_q;

    if (!en) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      to_fired_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          if (edge_q) begin
            state_d    = ST_MEAS;
            cnt_d      = CNT_W'(1);
            to_fired_d = 1'b0;
          end
        end
        ST_MEAS: begin
          if (edge_q) begin
            cnt_d          = CNT_W'(1);
            to_fired_d     = 1'b0;
            period_out_d   = cnt_q;
            period_valid_d = 1'b1;
            if (cnt_q < LO_V) begin
              period_err_d = 1'b1;
              too_short_d  = 1'b1;
              fail_cnt_d   = (fail_cnt_q == ALL1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
            end else if (cnt_q > HI_V) begin
              // A period already reported by the timeout is not counted twice.
              too_long_d = 1'b1;
              if (!to_fired_q) begin
                period_err_d = 1'b1;
                fail_cnt_d   = (fail_cnt_q == ALL1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
              end
            end else begin
              pass_cnt_d = (pass_cnt_q == ALL1) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = (cnt_q == ALL1) ? cnt_q : cnt_q + CNT_W'(1);
            if (TO_EN && !to_fired_q && (cnt_q == TO_V)) begin
              to_fired_d   = 1'b1;
              period_err_d = 1'b1;
              too_long_d   = 1'b1;
              fail_cnt_d   = (fail_cnt_q == ALL1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Set wins over clear, including a clear landing on the visible error pulse.
    err_sticky_d = period_err_d | period_err_q | (err_sticky_q & ~clr_sticky);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q         <= '0;
      s_dly_q        <= 1'b0;
      edge_q         <= 1'b0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      to_fired_q     <= 1'b0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      period_err_q   <= 1'b0;
      too_short_q    <= 1'b0;
      too_long_q     <= 1'b0;
      err_sticky_q   <= 1'b0;
      pass_cnt_q     <= '0;
      fail_cnt_q     <= '0;
    end else begin
      sync_q         <= sync_d;
      s_dly_q        <= s_dly_d;
      edge_q         <= edge_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_fired_q     <= to_fired_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      period_err_q   <= period_err_d;
      too_short_q    <= too_short_d;
      too_long_q     <= too_long_d;
      err_sticky_q   <= err_sticky_d;
      pass_cnt_q     <= pass_cnt_d;
      fail_cnt_q     <= fail_cnt_d;
    end
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign period_err   = period_err_q;
  assign too_short    = too_short_q;
  assign too_long     = too_long_q;
  assign err_sticky   = err_sticky_q;
  assign pass_cnt     = pass_cnt_q;
  assign fail_cnt     = fail_cnt_q;

endmodule
